// File: rtl/pixel_scale.sv
// pixel_scale: colour-processing stage between panel_pulse and pixel_driver.
//
// Each RGBA pixel is scaled by its own alpha (stage 1). It is then scaled by a
// global brightness that is latched once per frame and capped at MAX_BRIGHT
// (stage 2). Scaling is S(c,k) = (c*(k+1)) >> 8, so k=255 passes c through
// unchanged and k=0 gives 0. Output uses valid/ready with full backpressure.
//
// Optional build macro PIXEL_SCALE_GAMMA_EN adds a third registered stage. That
// stage maps each colour through a 256-entry gamma ROM,
// g(x) = round(255*(x/255)^2.2). Latency becomes 3 and capacity 3 pixels.
// Without the macro the outputs are linear and latency is 2.
//
// Ports:
//   clk                         system clock, all logic on posedge
//   reset                       synchronous active-high reset
//   in_valid / in_ready         upstream handshake
//   in_red/green/blue/alpha     upstream pixel (8 bits each)
//   in_last                     final pixel of its frame
//   brightness                  global brightness, sampled at frame start only
//   out_valid / out_ready       downstream handshake
//   out_red/green/blue          scaled pixel (8 bits each)
//   out_last                    in_last carried alongside its pixel

module pixel_scale #(
  parameter int BRIGHT_RESET = 255,
  parameter int MAX_BRIGHT   = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_red,
  input  logic [7:0] in_green,
  input  logic [7:0] in_blue,
  input  logic [7:0] in_alpha,
  input  logic       in_last,
  input  logic [7:0] brightness,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_red,
  output logic [7:0] out_green,
  output logic [7:0] out_blue,
  output logic       out_last
);

  localparam logic [7:0] MAX_B       = (MAX_BRIGHT > 255) ? 8'd255 : 8'(MAX_BRIGHT);
  localparam logic [7:0] BRIGHT_INIT = (BRIGHT_RESET < MAX_BRIGHT) ? 8'(BRIGHT_RESET) : MAX_B;

  // The 16-bit product never overflows: 255 * 256 = 65280.
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] k);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, k} + 16'd1);
    return 8'(prod >> 8);
  endfunction

  // Channel index 2 = red, 1 = green, 0 = blue.
  logic [2:0][7:0] pix_c;
  logic [2:0][7:0] s1_c_reg, s1_c_next;
  logic [2:0][7:0] s2_c_reg, s2_c_next;
  logic            s1_valid_reg, s1_last_reg;
  logic            s2_valid_reg, s2_last_reg;
  logic [7:0]      s1_bright_reg;
  logic [7:0]      bright_q_reg;
  logic [7:0]      bright_next;
  logic            frame_start_reg;
  logic            accept;
  logic            s2_load;
  logic            s2_leave;

  assign pix_c = {in_red, in_green, in_blue};

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    assign s1_c_next[gi] = scale(pix_c[gi], in_alpha);
    assign s2_c_next[gi] = scale(s1_c_reg[gi], s1_bright_reg);
  end

  // A frame-start pixel takes the fresh (capped) request. Every pixel carries
  // its brightness through stage 1, so stage 2 never sees a mid-frame change.
  assign bright_next = frame_start_reg ? ((brightness > MAX_B) ? MAX_B : brightness)
                                       : bright_q_reg;

  // Stage 2 loads when stage 1 holds data and stage 2 is empty or draining.
  // Stage 1 can take a new pixel if it is empty or is moving into stage 2.
  assign s2_load  = s1_valid_reg & (~s2_valid_reg | s2_leave);
  assign in_ready = ~s1_valid_reg | s2_load;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg    <= 1'b0;
      s1_c_reg        <= '0;
      s1_last_reg     <= 1'b0;
      s1_bright_reg   <= '0;
      bright_q_reg    <= BRIGHT_INIT;
      frame_start_reg <= 1'b1;
    end else if (accept) begin
      s1_valid_reg    <= 1'b1;
      s1_c_reg        <= s1_c_next;
      s1_last_reg     <= in_last;
      s1_bright_reg   <= bright_next;
      bright_q_reg    <= bright_next;
      frame_start_reg <= in_last;
    end else if (s2_load) begin
      s1_valid_reg    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_reg <= 1'b0;
      s2_c_reg     <= '0;
      s2_last_reg  <= 1'b0;
    end else if (s2_load) begin
      s2_valid_reg <= 1'b1;
      s2_c_reg     <= s2_c_next;
      s2_last_reg  <= s1_last_reg;
    end else if (s2_leave) begin
      s2_valid_reg <= 1'b0;
    end
  end

`ifdef PIXEL_SCALE_GAMMA_EN
  // Gamma ROM built at elaboration time; read is registered in stage 3.
  logic [7:0]      gamma_rom [256];
  logic [2:0][7:0] s3_c_reg, s3_c_next;
  logic            s3_valid_reg, s3_last_reg;

  for (genvar gi = 0; gi < 256; gi++) begin : g_gamma
    localparam int GV = $rtoi(255.0 * ((real'(gi) / 255.0) ** 2.2) + 0.5);
    assign gamma_rom[gi] = 8'(GV);
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_gamma_chan
    assign s3_c_next[gi] = gamma_rom[s2_c_reg[gi]];
  end

  assign s2_leave = s2_valid_reg & (~s3_valid_reg | out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      s3_valid_reg <= 1'b0;
      s3_c_reg     <= '0;
      s3_last_reg  <= 1'b0;
    end else if (s2_leave) begin
      s3_valid_reg <= 1'b1;
      s3_c_reg     <= s3_c_next;
      s3_last_reg  <= s2_last_reg;
    end else if (out_ready) begin
      s3_valid_reg <= 1'b0;
    end
  end

  assign out_valid = s3_valid_reg;
  assign out_red   = s3_c_reg[2];
  assign out_green = s3_c_reg[1];
  assign out_blue  = s3_c_reg[0];
  assign out_last  = s3_last_reg;
`else
  // Stage 2 is the output register: it drains whenever downstream accepts.
  assign s2_leave = out_ready;

  assign out_valid = s2_valid_reg;
  assign out_red   = s2_c_reg[2];
  assign out_green = s2_c_reg[1];
  assign out_blue  = s2_c_reg[0];
  assign out_last  = s2_last_reg;
`endif

endmodule

// File: tb/tb_pixel_scale.sv
// Directed testbench for pixel_scale: reset state, alpha/brightness scaling,
// brightness cap, per-frame latch, backpressure ordering and mid-stream reset.
// Also checks gamma points when PIXEL_SCALE_GAMMA_EN is defined.

module tb_pixel_scale;

`ifdef PIXEL_SCALE_GAMMA_EN
  localparam int LAT = 3;
  localparam int CAP = 3;
`else
  localparam int LAT = 2;
  localparam int CAP = 2;
`endif

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_red, in_green, in_blue, in_alpha;
  logic       in_last;
  logic [7:0] brightness;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_red, out_green, out_blue;
  logic       out_last;

  logic       c_in_ready;
  logic       c_out_valid;
  logic [7:0] c_out_red, c_out_green, c_out_blue;
  logic       c_out_last;

  int checks   = 0;
  int failures = 0;

  pixel_scale dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue), .in_alpha(in_alpha),
    .in_last(in_last), .brightness(brightness), .out_valid(out_valid),
    .out_ready(out_ready), .out_red(out_red), .out_green(out_green),
    .out_blue(out_blue), .out_last(out_last)
  );

  // Second instance with a brightness cap of 64 sharing the same stimulus.
  pixel_scale #(.BRIGHT_RESET(255), .MAX_BRIGHT(64)) dut_cap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue), .in_alpha(in_alpha),
    .in_last(in_last), .brightness(brightness), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_red(c_out_red), .out_green(c_out_green),
    .out_blue(c_out_blue), .out_last(c_out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected final output for a linear value x (gamma applied when enabled).
  function automatic logic [7:0] expv(input int x);
`ifdef PIXEL_SCALE_GAMMA_EN
    return 8'($rtoi(255.0 * ((real'(x) / 255.0) ** 2.2) + 0.5));
`else
    return 8'(x);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int r, input int g, input int b, input int a, input logic l);
    in_red   = 8'(r);
    in_green = 8'(g);
    in_blue  = 8'(b);
    in_alpha = 8'(a);
    in_last  = l;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_red !== 8'd0) begin failures++; $display("FAIL reset_out_red got=%0d exp=0", out_red); end
    checks++; if (out_green !== 8'd0) begin failures++; $display("FAIL reset_out_green got=%0d exp=0", out_green); end
    checks++; if (out_blue !== 8'd0) begin failures++; $display("FAIL reset_out_blue got=%0d exp=0", out_blue); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    $display("reset: out_valid=%b out_rgb=%0d/%0d/%0d in_ready=%b", out_valid, out_red, out_green, out_blue, in_ready);
    step();
  endtask

  task automatic test_basic();
    int first;
    int pulses;
    logic [23:0] rgb;
    logic l;
    first = -1; pulses = 0; rgb = '0; l = 1'b0;
    brightness = 8'd128;
    out_ready  = 1'b1;
    set_pix(200, 255, 0, 255, 1'b1);
    in_valid = 1'b1;
    #3;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #3;
      if (out_valid === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = k;
          rgb = {out_red, out_green, out_blue};
          l = out_last;
        end
      end
      step();
    end
    $display("basic: latency=%0d pulses=%0d rgb=%0d/%0d/%0d last=%b", first, pulses, rgb[23:16], rgb[15:8], rgb[7:0], l);
    checks++; if (first != LAT) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", first, LAT); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL basic_pulses got=%0d exp=1", pulses); end
    checks++; if (rgb !== {expv(100), expv(128), expv(0)}) begin failures++;
      $display("FAIL basic_rgb got=%0d/%0d/%0d exp=%0d/%0d/%0d", rgb[23:16], rgb[15:8], rgb[7:0], expv(100), expv(128), expv(0)); end
    checks++; if (l !== 1'b1) begin failures++; $display("FAIL basic_last got=%b exp=1", l); end
  endtask

  task automatic test_alpha_cap();
    logic [23:0] mv [2];
    logic [23:0] cv [2];
    logic [23:0] me [2];
    logic [23:0] ce [2];
    int nm;
    int nc;
    nm = 0; nc = 0;
    mv[0] = '0; mv[1] = '0; cv[0] = '0; cv[1] = '0;
    me[0] = {expv(0), expv(0), expv(0)};
    me[1] = {expv(200), expv(10), expv(255)};
    ce[0] = {expv(0), expv(0), expv(0)};
    ce[1] = {expv(50), expv(2), expv(64)};
    brightness = 8'd255;
    out_ready  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 0) begin set_pix(77, 77, 77, 0, 1'b1); in_valid = 1'b1; end
      else if (k == 1) begin set_pix(200, 10, 255, 255, 1'b1); in_valid = 1'b1; end
      else in_valid = 1'b0;
      #3;
      if (out_valid === 1'b1) begin
        if (nm < 2) mv[nm] = {out_red, out_green, out_blue};
        nm++;
      end
      if (c_out_valid === 1'b1) begin
        if (nc < 2) cv[nc] = {c_out_red, c_out_green, c_out_blue};
        nc++;
      end
      step();
    end
    for (int i = 0; i < 2; i++)
      $display("alpha_cap: pixel %0d main=%0d/%0d/%0d capped=%0d/%0d/%0d", i,
               mv[i][23:16], mv[i][15:8], mv[i][7:0], cv[i][23:16], cv[i][15:8], cv[i][7:0]);
    checks++; if (nm != 2) begin failures++; $display("FAIL alpha_count got=%0d exp=2", nm); end
    checks++; if (nc != 2) begin failures++; $display("FAIL cap_count got=%0d exp=2", nc); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (mv[i] !== me[i]) begin failures++; $display("FAIL alpha_main_%0d got=%h exp=%h", i, mv[i], me[i]); end
      checks++; if (cv[i] !== ce[i]) begin failures++; $display("FAIL cap_%0d got=%h exp=%h", i, cv[i], ce[i]); end
    end
  endtask

  task automatic test_frame_latch();
    logic [7:0] got [5];
    logic       gl  [5];
    int n;
    int vals [5];
    vals = '{10, 20, 30, 40, 50};
    n = 0;
    for (int i = 0; i < 5; i++) begin got[i] = '0; gl[i] = 1'b0; end
    out_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (k < 5) begin
        set_pix(vals[k], 0, 0, 255, (k == 3 || k == 4));
        brightness = (k == 0) ? 8'd255 : 8'd0;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #3;
      if (out_valid === 1'b1) begin
        if (n < 5) begin got[n] = out_red; gl[n] = out_last; end
        n++;
      end
      step();
    end
    checks++; if (n != 5) begin failures++; $display("FAIL latch_count got=%0d exp=5", n); end
    for (int i = 0; i < 5; i++) begin
      $display("frame_latch: pixel %0d red=%0d last=%b", i, got[i], gl[i]);
      checks++; if (got[i] !== expv(i < 4 ? vals[i] : 0)) begin failures++;
        $display("FAIL latch_pix_%0d got=%0d exp=%0d", i, got[i], expv(i < 4 ? vals[i] : 0)); end
    end
    checks++; if (gl[3] !== 1'b1 || gl[2] !== 1'b0) begin failures++;
      $display("FAIL latch_last got=%b%b exp=10", gl[3], gl[2]); end
  endtask

  task automatic test_backpressure();
    logic [31:0] pat;
    logic [7:0]  got [$];
    logic        got_last [$];
    logic        stalled;
    logic [7:0]  held;
    logic        held_last;
    logic        exp_ready;
    int idx;
    int occ;
    int cyc;
    int extra;
    pat = 32'hB2E4_6D39;
    idx = 0; occ = 0; cyc = 0; stalled = 1'b0; held = '0; held_last = 1'b0; extra = 0;
    brightness = 8'd255;
    while (cyc < 200 && got.size() < 10) begin
      out_ready = pat[cyc % 32];
      if (idx < 10) begin
        set_pix(idx + 1, 0, 0, 255, (idx == 9));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #3;
      if (stalled) begin
        checks++;
        if ({out_valid, out_red, out_last} !== {1'b1, held, held_last}) begin failures++;
          $display("FAIL bp_stable cyc=%0d got=%b/%0d/%b exp=1/%0d/%b", cyc, out_valid, out_red, out_last, held, held_last); end
      end
      exp_ready = !(occ == CAP && out_ready == 1'b0);
      checks++; if (in_ready !== exp_ready) begin failures++;
        $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b occ=%0d", cyc, in_ready, exp_ready, occ); end
      if (out_valid === 1'b1 && out_ready) begin
        got.push_back(out_red);
        got_last.push_back(out_last);
        occ--;
        $display("backpressure: cyc=%0d emit red=%0d last=%b", cyc, out_red, out_last);
      end
      if (in_valid && in_ready === 1'b1) begin
        idx++;
        occ++;
      end
      stalled   = (out_valid === 1'b1) && !out_ready;
      held      = out_red;
      held_last = out_last;
      step();
      cyc++;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #3;
      if (out_valid === 1'b1) extra++;
      step();
    end
    checks++; if (got.size() != 10) begin failures++; $display("FAIL bp_count got=%0d exp=10", got.size()); end
    checks++; if (extra != 0) begin failures++; $display("FAIL bp_extra got=%0d exp=0", extra); end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      checks++; if (got[i] !== expv(i + 1)) begin failures++; $display("FAIL bp_order_%0d got=%0d exp=%0d", i, got[i], expv(i + 1)); end
    end
    if (got.size() == 10) begin
      checks++; if (got_last[9] !== 1'b1 || got_last[8] !== 1'b0) begin failures++;
        $display("FAIL bp_last got=%b%b exp=10", got_last[9], got_last[8]); end
    end
  endtask

`ifdef PIXEL_SCALE_GAMMA_EN
  task automatic test_gamma();
    logic [7:0] got [3];
    logic [7:0] exp_g [3];
    int src [3];
    int n;
    src = '{128, 255, 0};
    exp_g[0] = 8'd56; exp_g[1] = 8'd255; exp_g[2] = 8'd0;
    got[0] = '0; got[1] = '0; got[2] = '0;
    n = 0;
    brightness = 8'd255;
    out_ready  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k < 3) begin set_pix(src[k], src[k], src[k], 255, 1'b1); in_valid = 1'b1; end
      else in_valid = 1'b0;
      #3;
      if (out_valid === 1'b1) begin
        if (n < 3) got[n] = out_red;
        n++;
      end
      step();
    end
    checks++; if (n != 3) begin failures++; $display("FAIL gamma_count got=%0d exp=3", n); end
    for (int i = 0; i < 3; i++) begin
      $display("gamma: in=%0d out=%0d", src[i], got[i]);
      checks++; if (got[i] !== exp_g[i]) begin failures++; $display("FAIL gamma_%0d got=%0d exp=%0d", i, got[i], exp_g[i]); end
    end
  endtask
`endif

  task automatic test_reset_mid();
    int stale;
    int first;
    logic [7:0] r;
    stale = 0; first = -1; r = '0;
    out_ready  = 1'b0;
    brightness = 8'd100;
    for (int i = 0; i < CAP; i++) begin
      set_pix(11 * (i + 1), 0, 0, 255, 1'b0);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rmid_full_valid got=%b exp=1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rmid_full_ready got=%b exp=0", in_ready); end
    step();
    reset = 1'b1;
    step();
    #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (dut.bright_q_reg !== 8'd255) begin failures++; $display("FAIL rmid_bright_q got=%0d exp=255", dut.bright_q_reg); end
    checks++; if (dut_cap.bright_q_reg !== 8'd64) begin failures++; $display("FAIL rmid_cap_bright_q got=%0d exp=64", dut_cap.bright_q_reg); end
    step();
    reset = 1'b0;
    out_ready  = 1'b1;
    brightness = 8'd64;
    for (int k = 0; k < 5; k++) begin
      #3;
      if (out_valid === 1'b1) stale++;
      step();
    end
    checks++; if (stale != 0) begin failures++; $display("FAIL rmid_stale got=%0d exp=0", stale); end
    set_pix(200, 0, 0, 255, 1'b1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #3;
      if (out_valid === 1'b1 && first < 0) begin first = k; r = out_red; end
      step();
    end
    $display("reset_mid: stale=%0d post_reset latency=%0d red=%0d", stale, first, r);
    checks++; if (first != LAT) begin failures++; $display("FAIL rmid_latency got=%0d exp=%0d", first, LAT); end
    checks++; if (r !== expv(50)) begin failures++; $display("FAIL rmid_rearm got=%0d exp=%0d", r, expv(50)); end
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    set_pix(0, 0, 0, 0, 1'b0);
    brightness = 8'd0;
    out_ready  = 1'b1;
    step();
    test_reset();
    test_basic();
    test_alpha_cap();
    test_frame_latch();
    test_backpressure();
`ifdef PIXEL_SCALE_GAMMA_EN
    test_gamma();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_scale.md
Name: pixel_scale

Overview:
- Colour-processing stage between the pattern generator (panel_pulse) and the LED serializer (pixel_driver).
- Takes RGBA pixels plus an end-of-frame marker. Applies per-pixel alpha, then a global brightness latched once per frame (capped for supply-current limiting).
- Presents 8-bit RGB to pixel_driver over a valid/ready handshake with full backpressure.
- Two-stage registered pipeline; the optional gamma stage adds a third.

Parameters:
- BRIGHT_RESET, 255: brightness register value after reset.
- MAX_BRIGHT, 255: cap on effective brightness; effective = min(brightness, MAX_BRIGHT).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream pixel valid.
- in_ready  output  1  block accepts a pixel this cycle.
- in_red, in_green, in_blue, in_alpha  input  8 each  upstream pixel.
- in_last  input  1  pixel is the final one of its frame.
- brightness  input  8  global brightness request; sampled only at frame start.
- out_valid  output  1  output pixel valid.
- out_ready  input  1  downstream (pixel_driver) accepts.
- out_red, out_green, out_blue  output  8 each  scaled pixel.
- out_last  output  1  in_last carried alongside its pixel.

Behaviour:
- Scale operator: S(c,k) = (c*(k+1)) >> 8, using a 16-bit product, then truncation.
  - S(c,255) = c; S(c,0) = 0.
- Stage 1 registers S(in_c, in_alpha) for each colour, plus last.
- Stage 2 registers S(s1_c, bright_q) for each colour, plus last. Stage 2 is the output register.
- bright_q handling:
  - Loaded with min(brightness, MAX_BRIGHT) on acceptance of the first pixel of a frame, i.e. the first accepted pixel after reset or after an accepted in_last pixel.
  - That pixel uses the newly loaded value. brightness changes mid-frame have no effect until the next frame.
  - To get this, the frame-start pixel carries the new value through stage 1 alongside its data.
- Transfers: accept = in_valid & in_ready; emit = out_valid & out_ready.
- Each stage holds a valid bit. A stage advances when its successor is empty or is emitting/advancing in the same cycle.
- in_ready = ~s1_valid | ~s2_valid | out_ready (combinational).
- Latency: accepted pixel appears on out_valid 2 cycles later with out_ready held high. Sustained throughput is 1 pixel/cycle.
- Backpressure: while out_valid & ~out_ready, the out_* values and out_last stay stable. The pipeline holds at most 2 pixels; no pixel is dropped or duplicated.
- Simultaneous accept and emit with the pipeline full: legal, and occupancy stays at 2.
- Reset state:
  - s1_valid = s2_valid = 0; out_valid = 0; out_* = 0; out_last = 0.
  - bright_q = min(BRIGHT_RESET, MAX_BRIGHT); frame-start flag = 1.
  - in_ready = 1 from the first cycle after reset.
- Reset mid-operation: in-flight pixels are discarded and out_valid falls on the next edge. The frame-start flag is re-armed.
- No internal frame counter: frame length is defined solely by in_last.

Optional Feature:
- Macro: PIXEL_SCALE_GAMMA_EN.
- When defined:
  - A third registered stage maps each colour through a 256-entry gamma LUT, g(x) = round(255*(x/255)^2.2), after brightness scaling.
  - Latency becomes 3 cycles; capacity is 3 pixels; in_ready generalizes to "any stage empty or out_ready".
  - Required points: g(0)=0, g(128)=56, g(255)=255.
- When undefined: no LUT, latency 2, outputs are linear.

Test Plan:
- Basic scaling: reset, brightness=128, out_ready=1, send R=200 G=255 B=0 alpha=255 -> 2 cycles later R=100 G=128 B=0, out_valid pulses 1 cycle.
- Alpha and cap: alpha=0 with any colour -> 0,0,0. MAX_BRIGHT=64, brightness=255, R=200 alpha=255 -> R=50.
- Frame latch: brightness=255 on pixel 0 of a 4-pixel frame (in_last on pixel 3), change to 0 before pixel 1 -> pixels 0-3 unscaled; first pixel of next frame -> 0.
- Backpressure: stream 10 pixels (values 1..10, alpha 255, bright 255) with out_ready toggling pseudo-randomly -> outputs 1..10 in order, none dropped or duplicated, out_* stable while stalled, in_ready=0 only with 2 held and out_ready=0.
- Reset mid-stream: reset asserted with 2 pixels in flight -> out_valid=0 next cycle, no stale pixel after release, bright_q=BRIGHT_RESET.
- PIXEL_SCALE_GAMMA_EN defined: R=128 alpha=255 bright=255 -> R=56 after 3 cycles; 255 -> 255; 0 -> 0.
